// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, D-cache freezes and
// branch redirects that can straddle an I-cache miss. Define HAZARD_PERF_EN for perf counters.
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_br_taken_i,
  input  logic [31:0]       ex_br_target_i,
  input  logic              imem_stall_i,
  input  logic              dmem_stall_i,
  output logic              pc_load_o,
  output logic              pc_redirect_o,
  output logic [31:0]       pc_target_o,
  output logic              if_id_load_o,
  output logic              id_ex_load_o,
  output logic              ex_mem_load_o,
  output logic              mem_wb_load_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ctrl_state_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_count_o
);

  typedef enum logic [0:0] {StRun, StRedirWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic        load_use;

  assign load_use = ex_valid_i && ex_is_load_i && (ex_rd_i != '0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  assign ctrl_state_o = (state_q == StRedirWait);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // A D-cache freeze holds everything; EX keeps presenting any branch until it lifts.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (!dmem_stall_i) begin
      unique case (state_q)
        StRun: begin
          if (ex_br_taken_i && imem_stall_i) begin
            state_d  = StRedirWait;
            target_d = ex_br_target_i;
          end
        end
        StRedirWait: begin
          if (!imem_stall_i) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_load_o     = 1'b1;
    pc_redirect_o = 1'b0;
    pc_target_o   = target_q;
    if_id_load_o  = 1'b1;
    id_ex_load_o  = 1'b1;
    ex_mem_load_o = 1'b1;
    mem_wb_load_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;

    if (!rst_ni) begin
      pc_load_o     = 1'b0;
      pc_target_o   = '0;
      if_id_load_o  = 1'b0;
      id_ex_load_o  = 1'b0;
      ex_mem_load_o = 1'b0;
      mem_wb_load_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (dmem_stall_i) begin
      pc_load_o     = 1'b0;
      if_id_load_o  = 1'b0;
      id_ex_load_o  = 1'b0;
      ex_mem_load_o = 1'b0;
      mem_wb_load_o = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_br_taken_i) begin
            // Redirect wins over any load-use match in the same cycle.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            pc_target_o   = ex_br_target_i;
            pc_load_o     = !imem_stall_i;
            pc_redirect_o = !imem_stall_i;
          end else if (load_use || imem_stall_i) begin
            pc_load_o     = 1'b0;
            if_id_load_o  = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        StRedirWait: begin
          id_ex_flush_o = 1'b1;
          if (imem_stall_i) begin
            pc_load_o    = 1'b0;
            if_id_load_o = 1'b0;
          end else begin
            // The fetch returning now is from the wrong path.
            if_id_flush_o = 1'b1;
            pc_redirect_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_load_o)    stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (if_id_flush_o) flush_count_q  <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; outputs are sampled 2 time units after each rising edge.
module tb_hazard_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i, ex_valid_i, ex_is_load_i;
  logic        ex_br_taken_i, imem_stall_i, dmem_stall_i;
  logic [31:0] ex_br_target_i;
  logic        pc_load_o, pc_redirect_o, if_id_load_o, id_ex_load_o;
  logic        ex_mem_load_o, mem_wb_load_o, if_id_flush_o, id_ex_flush_o, ctrl_state_o;
  logic [31:0] pc_target_o, stall_cycles_o, flush_count_o;

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_uses_rs1_i  (id_uses_rs1_i),
    .id_uses_rs2_i  (id_uses_rs2_i),
    .ex_valid_i     (ex_valid_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .ex_br_taken_i  (ex_br_taken_i),
    .ex_br_target_i (ex_br_target_i),
    .imem_stall_i   (imem_stall_i),
    .dmem_stall_i   (dmem_stall_i),
    .pc_load_o      (pc_load_o),
    .pc_redirect_o  (pc_redirect_o),
    .pc_target_o    (pc_target_o),
    .if_id_load_o   (if_id_load_o),
    .id_ex_load_o   (id_ex_load_o),
    .ex_mem_load_o  (ex_mem_load_o),
    .mem_wb_load_o  (mem_wb_load_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ctrl_state_o   (ctrl_state_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
    ex_br_taken_i = 1'b0; ex_br_target_i = 32'h0;
    imem_stall_i = 1'b0; dmem_stall_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o} !== 5'b0) begin
      errors++; $display("FAIL reset_loads: got %b want 00000",
        {pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o});
    end
    checks++;
    if ({if_id_flush_o, id_ex_flush_o, pc_redirect_o, ctrl_state_o} !== 4'b1100) begin
      errors++; $display("FAIL reset_flush_state: got %b want 1100",
        {if_id_flush_o, id_ex_flush_o, pc_redirect_o, ctrl_state_o});
    end
    checks++;
    if (pc_target_o !== 32'h0) begin
      errors++; $display("FAIL reset_target: got %h want 00000000", pc_target_o);
    end
    step(); step();
    rst_ni = 1'b1;
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, if_id_flush_o, id_ex_flush_o} !== 4'b1100) begin
      errors++; $display("FAIL run_idle: got %b want 1100",
        {pc_load_o, if_id_load_o, if_id_flush_o, id_ex_flush_o});
    end
  endtask

  task automatic test_load_use();
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_uses_rs1_i = 1'b1;
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_flush_o, ex_mem_load_o, mem_wb_load_o} !== 5'b00111) begin
      errors++; $display("FAIL lu_stall: got %b want 00111",
        {pc_load_o, if_id_load_o, id_ex_flush_o, ex_mem_load_o, mem_wb_load_o});
    end
    step();
    ex_valid_i = 1'b0;  // bubble now in EX
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_load_o, if_id_flush_o, id_ex_flush_o} !== 5'b11100) begin
      errors++; $display("FAIL lu_release: got %b want 11100",
        {pc_load_o, if_id_load_o, id_ex_load_o, if_id_flush_o, id_ex_flush_o});
    end
    // rs2 match also stalls
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd9;
    id_rs2_i = 5'd9; id_uses_rs2_i = 1'b1; id_rs1_i = 5'd9;
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_flush_o} !== 3'b001) begin
      errors++; $display("FAIL lu_rs2: got %b want 001", {pc_load_o, if_id_load_o, id_ex_flush_o});
    end
  endtask

  task automatic test_no_stall();
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd0;
    id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1; id_uses_rs2_i = 1'b1;
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_flush_o} !== 3'b110) begin
      errors++; $display("FAIL x0_no_stall: got %b want 110", {pc_load_o, if_id_load_o, id_ex_flush_o});
    end
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_uses_rs1_i = 1'b0;
    #1;
    checks++;
    if ({pc_load_o, if_id_load_o, id_ex_flush_o} !== 3'b110) begin
      errors++; $display("FAIL nouse_no_stall: got %b want 110",
        {pc_load_o, if_id_load_o, id_ex_flush_o});
    end
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_rd_i = 5'd5;
    id_rs1_i = 5'd5; id_uses_rs1_i = 1'b1;
    #1;
    checks++;
    if (pc_load_o !== 1'b1) begin
      errors++; $display("FAIL nonload_no_stall: got %b want 1", pc_load_o);
    end
  endtask

  task automatic test_clean_redirect();
    step();
    idle_inputs();
    ex_br_taken_i = 1'b1; ex_br_target_i = 32'h0000_1040;
    #1;
    checks++;
    if ({pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o, ctrl_state_o} !== 5'b11110) begin
      errors++; $display("FAIL redir_ctrl: got %b want 11110",
        {pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o, ctrl_state_o});
    end
    checks++;
    if (pc_target_o !== 32'h0000_1040) begin
      errors++; $display("FAIL redir_target: got %h want 00001040", pc_target_o);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if ({ctrl_state_o, pc_redirect_o, pc_load_o} !== 3'b001) begin
      errors++; $display("FAIL redir_after: got %b want 001", {ctrl_state_o, pc_redirect_o, pc_load_o});
    end
  endtask

  task automatic test_redirect_imiss();
    step();
    idle_inputs();
    ex_br_taken_i = 1'b1; ex_br_target_i = 32'h0000_2000; imem_stall_i = 1'b1;
    #1;
    checks++;
    if ({pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o} !== 4'b0011 ||
        pc_target_o !== 32'h0000_2000) begin
      errors++; $display("FAIL imiss_first: got %b/%h want 0011/00002000",
        {pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o}, pc_target_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      ex_br_taken_i = (i == 1);  // stray branch during wait must be ignored
      ex_br_target_i = 32'h0000_3000;
      #1;
      checks++;
      if ({ctrl_state_o, pc_load_o, if_id_load_o, id_ex_flush_o} !== 4'b1001 ||
          pc_target_o !== 32'h0000_2000) begin
        errors++; $display("FAIL imiss_wait%0d: got %b/%h want 1001/00002000", i,
          {ctrl_state_o, pc_load_o, if_id_load_o, id_ex_flush_o}, pc_target_o);
      end
    end
    step();
    ex_br_taken_i = 1'b0; imem_stall_i = 1'b0;
    #1;
    checks++;
    if ({ctrl_state_o, pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o} !== 5'b11111 ||
        pc_target_o !== 32'h0000_2000) begin
      errors++; $display("FAIL imiss_release: got %b/%h want 11111/00002000",
        {ctrl_state_o, pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o}, pc_target_o);
    end
    step();
    #1;
    checks++;
    if ({ctrl_state_o, pc_redirect_o, pc_load_o} !== 3'b001) begin
      errors++; $display("FAIL imiss_back_run: got %b want 001",
        {ctrl_state_o, pc_redirect_o, pc_load_o});
    end
  endtask

  task automatic test_dstall_priority();
    step();
    idle_inputs();
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd7;
    id_rs1_i = 5'd7; id_uses_rs1_i = 1'b1;
    ex_br_taken_i = 1'b1; ex_br_target_i = 32'h0000_4000;
    imem_stall_i = 1'b1; dmem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, ctrl_state_o} !== 8'b0) begin
        errors++; $display("FAIL dstall_freeze%0d: got %b want 00000000", i,
          {pc_load_o, if_id_load_o, id_ex_load_o, ex_mem_load_o, mem_wb_load_o,
           if_id_flush_o, id_ex_flush_o, ctrl_state_o});
      end
      step();
    end
    dmem_stall_i = 1'b0; imem_stall_i = 1'b0;
    #1;
    checks++;
    if ({pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o} !== 4'b1111 ||
        pc_target_o !== 32'h0000_4000) begin
      errors++; $display("FAIL dstall_release: got %b/%h want 1111/00004000",
        {pc_load_o, pc_redirect_o, if_id_flush_o, id_ex_flush_o}, pc_target_o);
    end
  endtask

  task automatic test_reset_redir_wait();
    step();
    idle_inputs();
    ex_br_taken_i = 1'b1; ex_br_target_i = 32'h0000_5000; imem_stall_i = 1'b1;
    step();
    ex_br_taken_i = 1'b0;
    #1;
    checks++;
    if (ctrl_state_o !== 1'b1) begin
      errors++; $display("FAIL rr_enter: got %b want 1", ctrl_state_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ctrl_state_o, if_id_flush_o, id_ex_flush_o, pc_load_o} !== 4'b0110 ||
        pc_target_o !== 32'h0) begin
      errors++; $display("FAIL rr_async: got %b/%h want 0110/00000000",
        {ctrl_state_o, if_id_flush_o, id_ex_flush_o, pc_load_o}, pc_target_o);
    end
    checks++;
    if (stall_cycles_o !== 32'h0 || flush_count_o !== 32'h0) begin
      errors++; $display("FAIL rr_counters: got %0d/%0d want 0/0", stall_cycles_o, flush_count_o);
    end
    step();
    imem_stall_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    checks++;
    if ({ctrl_state_o, pc_redirect_o, pc_load_o, if_id_flush_o} !== 4'b0010) begin
      errors++; $display("FAIL rr_abandoned: got %b want 0010",
        {ctrl_state_o, pc_redirect_o, pc_load_o, if_id_flush_o});
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step(); step();
    imem_stall_i = 1'b1;
    step(); step();
    imem_stall_i = 1'b0;
    ex_br_taken_i = 1'b1; ex_br_target_i = 32'h0000_0100;
    step();
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles_o !== 32'd2) begin
      errors++; $display("FAIL perf_stall: got %0d want 2", stall_cycles_o);
    end
    checks++;
    if (flush_count_o !== 32'd1) begin
      errors++; $display("FAIL perf_flush: got %0d want 1", flush_count_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_clean_redirect();
    test_redirect_imiss();
    test_dstall_priority();
    test_reset_redir_wait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB buffers and drives their load and flush enables, plus the PC load and redirect controls.
- Detects load-use hazards against the instruction in ID and freezes the pipe on D-cache stalls.
- Sequences taken-branch/jump redirects, including redirects that arrive while an I-cache miss is outstanding.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_AW  rs1 of the instruction in ID.
- id_rs2  in  REG_AW  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_br_taken  in  1  EX resolved a taken branch or jump.
- ex_br_target  in  32  redirect target from EX.
- imem_stall  in  1  I-cache response not ready this cycle.
- dmem_stall  in  1  D-cache access not complete this cycle.
- pc_load  out  1  PC register load enable.
- pc_redirect  out  1  pcmux selects pc_target (else pc+4).
- pc_target  out  32  redirect address.
- if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  buffer load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (valid=0) instead of data.
- ctrl_state  out  1  0=RUN, 1=REDIR_WAIT (debug).
- stall_cycles  out  CNT_W  optional counter (see Optional Feature).
- flush_count  out  CNT_W  optional counter (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN; internal target register cleared to 0.
  - While rst=0, all *_load=0, both flushes=1, pc_redirect=0, pc_target=0.
- Outputs are combinational from the state, the target register and the inputs. The state and target register are the only sequential elements (plus the optional counters).
- Hazard term: lu = ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in every state, highest first:
  1. dmem_stall=1: freeze. All loads=0, all flushes=0, pc_load=0. State and target are held. An ex_br_taken seen during a freeze is acted on only in the first unfrozen cycle, because EX is frozen and keeps presenting it.
  2. RUN & ex_br_taken:
     - if_id_flush=1, id_ex_flush=1.
     - ex_mem_load=1, mem_wb_load=1.
     - pc_target=ex_br_target.
     - If imem_stall=0: pc_load=1, pc_redirect=1; stay in RUN.
     - If imem_stall=1: pc_load=0; latch ex_br_target into the target register; next state REDIR_WAIT.
  3. REDIR_WAIT:
     - id_ex_flush=1; ex_mem_load=1, mem_wb_load=1; pc_target=latched target.
     - While imem_stall=1: pc_load=0, if_id_load=0.
     - First cycle with imem_stall=0: discard the wrong-path fetch (if_id_flush=1), pc_load=1, pc_redirect=1; next state RUN.
     - ex_br_taken is ignored in this state, since EX holds a bubble.
  4. RUN & lu:
     - pc_load=0, if_id_load=0.
     - id_ex_flush=1; ex_mem_load=1, mem_wb_load=1.
     - Lasts exactly one cycle per load-use pair, because the bubble clears the EX match.
  5. RUN & imem_stall:
     - pc_load=0, if_id_load=0.
     - id_ex_flush=1; downstream loads=1.
  6. Otherwise: all loads=1, flushes=0, pc_redirect=0.
- rd=x0 never causes a stall.
- A load-use match is suppressed when a redirect occurs in the same cycle (redirect wins).
- Reset asserted in REDIR_WAIT abandons the pending redirect.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - stall_cycles increments by 1 in each cycle where pc_load=0 and rst=1.
  - flush_count increments by 1 in each cycle with if_id_flush=1 after reset is released.
  - Both counters clear on reset and wrap modulo 2^CNT_W.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Load-use stall: EX lw x5 (ex_valid=1, ex_is_load=1, ex_rd=5), ID add reads rs1=5 -> exactly one cycle with pc_load=0, if_id_load=0, id_ex_flush=1; next cycle all loads=1.
- x0 and non-use cases: ex_rd=0, or id_uses_rs1=0 with rs1=5 against ex_rd=5 -> no stall.
- Clean redirect: ex_br_taken=1, ex_br_target=0x0000_1040, imem_stall=0 -> same cycle pc_load=1, pc_redirect=1, pc_target=0x1040, if_id_flush=1, id_ex_flush=1; state stays RUN.
- Redirect during I-miss: ex_br_taken=1, target=0x2000, imem_stall=1 for 3 more cycles -> ctrl_state=1 for 3 cycles with pc_load=0. On the cycle imem_stall drops: pc_load=1, pc_redirect=1, pc_target=0x2000, if_id_flush=1; then RUN.
- D-stall priority: dmem_stall=1 together with lu=1 and ex_br_taken=1 -> all loads 0, flushes 0. After dmem_stall drops, the redirect wins that cycle and no load-use stall occurs.
- Reset mid-REDIR_WAIT: drop rst asynchronously -> state RUN, pc_target=0, flushes=1 immediately. With HAZARD_PERF_EN, both counters read 0.
